pwm_carrier_gen: RTL and testbench

- Generates the symmetric triangle PWM carrier for the AMDC timing fabric.
- Emits one-cycle peak and valley strobes (carrier_high / carrier_low).
- These strobes are the event inputs consumed by the interrupt generator.
- Period and prescaler settings are shadowed and take effect only at a valley, so software writes never distort a running carrier cycle.

---
 rtl/pwm_carrier_gen.sv | 132 +++++++++++++
 tb/tb_pwm_carrier_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_carrier_gen.sv
// Symmetric triangle PWM carrier with peak/valley strobes.
// Period and prescaler requests are shadowed and only take effect at a valley.
module pwm_carrier_gen #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] carrier_max,
    input  logic [DIV_W-1:0] carrier_div,
    output logic [CNT_W-1:0] carrier,
    output logic             count_up,
    output logic             carrier_high,
    output logic             carrier_low,
    output logic             load_ack
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] carrier_q, carrier_d;
    logic             count_up_q, count_up_d;
    logic             high_q, high_d;
    logic             low_q, low_d;
    logic             ack_q, ack_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] max_act_q, max_act_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;

    logic [CNT_W-1:0] max_req;
    logic [CNT_W-1:0] carrier_inc;
    logic [CNT_W-1:0] carrier_dec;
    logic             tick;

    // A zero peak request would stall the carrier, so it is clamped to 1.
    assign max_req     = (carrier_max == '0) ? CNT_ONE : carrier_max;
    assign carrier_inc = carrier_q + CNT_ONE;
    assign carrier_dec = carrier_q - CNT_ONE;
    assign tick        = (presc_q == div_act_q);

    always_comb begin
        state_d    = state_q;
        carrier_d  = carrier_q;
        count_up_d = count_up_q;
        high_d     = 1'b0;
        low_d      = 1'b0;
        ack_d      = 1'b0;
        presc_d    = presc_q;
        max_act_d  = max_act_q;
        div_act_d  = div_act_q;

        case (state_q)
            IDLE: begin
                carrier_d  = '0;
                presc_d    = '0;
                count_up_d = 1'b0;
                if (enable) begin
                    max_act_d  = max_req;
                    div_act_d  = carrier_div;
                    ack_d      = 1'b1;
                    count_up_d = 1'b1;
                    state_d    = UP;
                end
            end
            UP, DOWN: begin
                if (!enable) begin
                    state_d    = IDLE;
                    carrier_d  = '0;
                    presc_d    = '0;
                    count_up_d = 1'b0;
                end else begin
                    presc_d = tick ? '0 : presc_q + DIV_ONE;
                    if (tick && state_q == UP) begin
                        carrier_d = carrier_inc;
                        if (carrier_inc == max_act_q) begin
                            high_d     = 1'b1;
                            count_up_d = 1'b0;
                            state_d    = DOWN;
                        end
                    end else if (tick) begin
                        carrier_d = carrier_dec;
                        // Valley: the only point where new settings are accepted.
                        if (carrier_dec == '0) begin
                            low_d      = 1'b1;
                            count_up_d = 1'b1;
                            state_d    = UP;
                            max_act_d  = max_req;
                            div_act_d  = carrier_div;
                            ack_d      = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            carrier_q  <= '0;
            count_up_q <= 1'b0;
            high_q     <= 1'b0;
            low_q      <= 1'b0;
            ack_q      <= 1'b0;
            presc_q    <= '0;
            max_act_q  <= CNT_ONE;
            div_act_q  <= '0;
        end else begin
            state_q    <= state_d;
            carrier_q  <= carrier_d;
            count_up_q <= count_up_d;
            high_q     <= high_d;
            low_q      <= low_d;
            ack_q      <= ack_d;
            presc_q    <= presc_d;
            max_act_q  <= max_act_d;
            div_act_q  <= div_act_d;
        end
    end

    assign carrier      = carrier_q;
    assign count_up     = count_up_q;
    assign carrier_high = high_q;
    assign carrier_low  = low_q;
    assign load_ack     = ack_q;

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Self-checking bench for pwm_carrier_gen: directed scenarios plus random
// stimulus against an arithmetic position-in-period reference model.
module tb_pwm_carrier_gen;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] carrier_max;
    logic [7:0]  carrier_div;
    logic [15:0] carrier;
    logic        count_up;
    logic        carrier_high;
    logic        carrier_low;
    logic        load_ack;

    int checks   = 0;
    int failures = 0;

    // Reference model: n = clk edges since the last shadow load (start or valley).
    bit m_idle   = 1;
    bit m_valley = 0;
    int m_max    = 1;
    int m_div    = 0;
    int m_n      = 0;

    logic [15:0] e_carrier;
    logic        e_up, e_high, e_low, e_ack;

    pwm_carrier_gen #(.CNT_W(16), .DIV_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .carrier_max  (carrier_max),
        .carrier_div  (carrier_div),
        .carrier      (carrier),
        .count_up     (count_up),
        .carrier_high (carrier_high),
        .carrier_low  (carrier_low),
        .load_ack     (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp_max(input logic [15:0] req);
        return (req == 16'd0) ? 1 : int'(req);
    endfunction

    task automatic model_expect();
        int s;
        bit t;
        if (m_idle) begin
            e_carrier = '0; e_up = 0; e_high = 0; e_low = 0; e_ack = 0;
        end else begin
            s = m_n / (m_div + 1);
            t = (m_n % (m_div + 1)) == 0;
            e_carrier = 16'((s <= m_max) ? s : 2 * m_max - s);
            e_up      = s < m_max;
            e_high    = t && (s == m_max);
            e_low     = (m_n == 0) && m_valley;
            e_ack     = (m_n == 0);
        end
    endtask

    task automatic model_edge();
        if (!enable) begin
            m_idle = 1;
        end else if (m_idle) begin
            m_idle = 0; m_valley = 0; m_n = 0;
            m_max = clamp_max(carrier_max); m_div = int'(carrier_div);
        end else begin
            m_n++;
            if (m_n == 2 * m_max * (m_div + 1)) begin
                m_valley = 1; m_n = 0;
                m_max = clamp_max(carrier_max); m_div = int'(carrier_div);
            end
        end
        model_expect();
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".carrier"},  32'(carrier),      32'(e_carrier));
        check({tag, ".count_up"}, 32'(count_up),     32'(e_up));
        check({tag, ".high"},     32'(carrier_high), 32'(e_high));
        check({tag, ".low"},      32'(carrier_low),  32'(e_low));
        check({tag, ".ack"},      32'(load_ack),     32'(e_ack));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        m_idle = 1;
        model_expect();
        #1;
        compare_all(tag);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int seq_exp [8];
        int budget;
        seq_exp = '{0, 1, 2, 3, 2, 1, 0, 1};
        rst_n = 1'b0; enable = 1'b0; carrier_max = 16'd3; carrier_div = 8'd0;
        #12;
        model_expect();
        compare_all("reset");
        rst_n = 1'b1;
        step("idle");

        // Basic triangle with a literal sequence check.
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step("basic");
            check("basic_seq", 32'(carrier), 32'(seq_exp[i]));
        end
        repeat (8) step("basic");

        // Prescaler: new settings land at the next valley.
        carrier_max = 16'd2; carrier_div = 8'd2;
        repeat (40) step("presc");

        // Shadow update while carrier=1 in UP with max=4.
        carrier_max = 16'd4; carrier_div = 8'd0;
        budget = 0;
        while (!(m_max == 4 && m_div == 0 && !m_idle && e_up && e_carrier == 16'd1) && budget < 100) begin
            step("shadow_wait"); budget++;
        end
        check("shadow_timeout", 32'(budget < 100), 32'd1);
        carrier_max = 16'd2;
        repeat (16) step("shadow");

        // Zero request clamps to a 0,1 toggle.
        carrier_max = 16'd0;
        repeat (12) step("clamp");

        // Abort in DOWN at carrier=2 with max=5, then restart.
        carrier_max = 16'd5;
        budget = 0;
        while (!(m_max == 5 && !m_idle && !e_up && e_carrier == 16'd2) && budget < 100) begin
            step("abort_wait"); budget++;
        end
        check("abort_timeout", 32'(budget < 100), 32'd1);
        enable = 1'b0;
        step("abort");
        step("abort_idle");
        enable = 1'b1;
        repeat (6) step("restart");

        // Reset while carrier_high is asserted.
        carrier_max = 16'd3;
        budget = 0;
        while (!e_high && budget < 100) begin
            step("rst_wait"); budget++;
        end
        check("rst_timeout", 32'(budget < 100), 32'd1);
        reset_pulse("rst_mid");
        repeat (8) step("rst_after");

        // Random stimulus.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            if ($urandom_range(0, 7) == 0) carrier_max = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) carrier_div = 8'($urandom_range(0, 3));
            step("rand");
            if ($urandom_range(0, 99) == 0) reset_pulse("rand_rst");
        end

        // Full-scale peak: max = 2^16-1 from a fresh start.
        enable = 1'b0; carrier_max = 16'hFFFF; carrier_div = 8'd0;
        step("full_idle");
        enable = 1'b1;
        repeat (65540) step("full");
        check("full_peak_reached", 32'(m_n > 65535), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
